bpsk_tx: RTL and testbench



---
 rtl/bpsk_tx_pkg.sv | 85 ++++++++
 rtl/bpsk_tx_if.sv | 11 +
 rtl/bpsk_cordic_sin.sv | 51 +++++
 rtl/bpsk_tx.sv | 72 +++++++
 tb/tb_bpsk_tx.sv | 126 ++++++++++++
 5 files changed

// File: rtl/bpsk_tx_pkg.sv
// Shared constants, types and arithmetic helpers for the BPSK transmitter.
// The CORDIC step, atan table and output saturation live here so every stage uses the same definitions.
package bpsk_tx_pkg;

    localparam int ITER    = 16;
    localparam int DATA_W  = 16;
    localparam int INT_W   = 18;
    localparam int PHASE_W = 32;

    typedef logic        [PHASE_W-1:0] phase_t;
    typedef logic signed [INT_W-1:0]   xy_t;
    typedef logic signed [PHASE_W-1:0] z_t;
    typedef logic signed [DATA_W-1:0]  sample_t;

    localparam xy_t     X0      = 18'sd19896;
    localparam sample_t OUT_MAX = 16'sd32767;

    typedef struct packed {
        xy_t  x;
        xy_t  y;
        z_t   z;
        logic b;
        logic v;
    } cordic_stage_t;

    // atan(2^-i) scaled so that 2^32 is one full turn
    function automatic z_t atan_lut(input logic [3:0] i);
        z_t a;
        case (i)
            4'd0:    a = 32'sh2000_0000;
            4'd1:    a = 32'sh12E4_051E;
            4'd2:    a = 32'sh09FB_385B;
            4'd3:    a = 32'sh0511_11D4;
            4'd4:    a = 32'sh028B_0D43;
            4'd5:    a = 32'sh0145_D7E1;
            4'd6:    a = 32'sh00A2_F61E;
            4'd7:    a = 32'sh0051_7C55;
            4'd8:    a = 32'sh0028_BE53;
            4'd9:    a = 32'sh0014_5F2F;
            4'd10:   a = 32'sh000A_2F98;
            4'd11:   a = 32'sh0005_17CC;
            4'd12:   a = 32'sh0002_8BE6;
            4'd13:   a = 32'sh0001_45F3;
            4'd14:   a = 32'sh0000_A2FA;
            4'd15:   a = 32'sh0000_517D;
            default: a = 32'sd0;
        endcase
        return a;
    endfunction

    function automatic cordic_stage_t cordic_step(input cordic_stage_t s, input logic [3:0] i);
        cordic_stage_t n;
        xy_t           xs;
        xy_t           ys;
        z_t            a;
        n  = s;
        xs = s.x >>> i;
        ys = s.y >>> i;
        a  = atan_lut(i);
        // rotate toward zero residual angle
        if (s.z[PHASE_W-1] == 1'b0) begin
            n.x = s.x - ys;
            n.y = s.y + xs;
            n.z = s.z - a;
        end else begin
            n.x = s.x + ys;
            n.y = s.y - xs;
            n.z = s.z + a;
        end
        return n;
    endfunction

    function automatic sample_t sat_out(input xy_t v);
        sample_t r;
        if (v > 18'sd32767) begin
            r = OUT_MAX;
        end else if (v < -18'sd32767) begin
            r = -OUT_MAX;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bpsk_tx_if.sv
// Data bit, carrier phase increment and modulated sample exchanged with the transmitter.
interface bpsk_tx_if;
    import bpsk_tx_pkg::*;

    logic    bit_in;
    phase_t  phase_step;
    sample_t bpsk_out;

    modport master (output bit_in, output phase_step, input  bpsk_out);
    modport slave  (input  bit_in, input  phase_step, output bpsk_out);
endinterface

// File: rtl/bpsk_cordic_sin.sv
// Fully pipelined rotation-mode CORDIC: one register for quadrant folding, then one per iteration.
// The data bit and a valid flag ride along as sideband so each sine stays paired with its own bit.
module bpsk_cordic_sin
    import bpsk_tx_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  phase_t i_angle,
    input  logic   i_bit,
    output logic   o_valid,
    output xy_t    o_sin,
    output logic   o_bit
);

    cordic_stage_t [ITER:0] r_stage;
    cordic_stage_t          w_pre;
    logic                   w_neg;
    logic                   w_unused_z;

    // quadrants 1 and 2 are shifted by 180 deg, so start from -X0 to compensate
    assign w_neg = i_angle[31] ^ i_angle[30];

    // fold the input angle into -90..+90 deg
    always_comb begin
        w_pre   = '0;
        w_pre.x = w_neg ? -X0 : X0;
        w_pre.y = '0;
        w_pre.z = {i_angle[30], i_angle[30:0]};
        w_pre.b = i_bit;
        w_pre.v = i_valid;
    end

    // pre-rotation register followed by one register per iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= w_pre;
            for (int i = 0; i < ITER; i++) begin
                r_stage[i+1] <= cordic_step(r_stage[i], 4'(i));
            end
        end
    end

    assign o_valid    = r_stage[ITER].v;
    assign o_sin      = r_stage[ITER].y;
    assign o_bit      = r_stage[ITER].b;
    assign w_unused_z = ^{r_stage[ITER].z, r_stage[ITER].x};

endmodule

// File: rtl/bpsk_tx.sv
// BPSK transmitter: phase accumulator, per-sample capture of phase and bit, CORDIC sine, and
// sign mapping with symmetric saturation into a registered output.
module bpsk_tx
    import bpsk_tx_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bpsk_tx_if.slave     bus
);

    phase_t  r_acc;
    phase_t  r_cap_p;
    logic    r_cap_b;
    logic    r_cap_v;
    sample_t r_out;

    logic    w_v;
    xy_t     w_y;
    logic    w_b;
    xy_t     w_mapped;
    sample_t w_out;

    // accumulator and capture of the pre-update phase with its bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_cap_p <= '0;
            r_cap_b <= 1'b0;
            r_cap_v <= 1'b0;
        end else begin
            r_acc   <= r_acc + bus.phase_step;
            r_cap_p <= r_acc;
            r_cap_b <= bus.bit_in;
            r_cap_v <= 1'b1;
        end
    end

    bpsk_cordic_sin u_cordic (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_cap_v),
        .i_angle (r_cap_p),
        .i_bit   (r_cap_b),
        .o_valid (w_v),
        .o_sin   (w_y),
        .o_bit   (w_b)
    );

    assign w_mapped = w_b ? w_y : -w_y;

    // samples still flushing out after reset are forced to zero
    always_comb begin
        w_out = '0;
        if (w_v) begin
            w_out = sat_out(w_mapped);
        end else begin
            w_out = '0;
        end
    end

    // output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_out;
        end
    end

    assign bus.bpsk_out = r_out;

endmodule

// File: tb/tb_bpsk_tx.sv
// Directed bench for bpsk_tx: a floating-point sine model with an 18-edge delay line predicts every
// output sample; quadrant steps are also compared against a hand-written constant table.
module tb_bpsk_tx;
    import bpsk_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bpsk_tx_if bus ();

    bpsk_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [31:0] m_acc;
    int          m_n;
    logic [31:0] h_p [0:4095];
    logic        h_b [0:4095];
    int          quad_tbl [4] = '{0, 32767, 0, -32767};

    function automatic int model(input logic [31:0] p, input logic b);
        real s;
        int  v;
        s = $sin(6.283185307179586 * real'(p) / 4294967296.0);
        v = int'(32767.0 * s);
        return b ? v : -v;
    endfunction

    task automatic check(input string tag, input int expv, input int tol);
        int   obs;
        int   err;
        logic ok;
        obs = int'(bus.bpsk_out);
        err = obs - expv;
        if (err < 0) err = -err;
        ok = (err <= tol) && (obs != -32768);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    // one clock edge: update the model with what the DUT captures, then compare after the edge
    task automatic tick(input string tag);
        if (rst) begin
            m_acc = 32'd0;
            m_n   = 0;
        end else if (m_n < 4096) begin
            h_p[m_n] = m_acc;
            h_b[m_n] = bus.bit_in;
            m_acc    = m_acc + bus.phase_step;
            m_n++;
        end
        @(posedge clk);
        #1;
        if (rst || m_n <= 18) begin
            check(tag, 0, 0);
        end else begin
            check(tag, model(h_p[m_n-19], h_b[m_n-19]), 8);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        m_acc          = 32'd0;
        m_n            = 0;
        rst            = 1'b1;
        bus.bit_in     = 1'b1;
        bus.phase_step = 32'd85899346;
        repeat (3) tick("reset");

        rst = 1'b0;
        repeat (120) tick("sine_b1");

        rst = 1'b1;
        tick("rst_b0");
        rst        = 1'b0;
        bus.bit_in = 1'b0;
        repeat (80) tick("sine_b0");

        for (int i = 0; i < 60; i++) begin
            bus.bit_in = 1'((i / 7) % 2);
            tick("toggle");
        end

        rst = 1'b1;
        tick("midrst");
        rst        = 1'b0;
        bus.bit_in = 1'b1;
        repeat (40) tick("post_rst");

        bus.phase_step = 32'd0;
        repeat (30) tick("hold");

        bus.phase_step = 32'h8000_0000;
        repeat (30) tick("nyquist");

        rst = 1'b1;
        tick("rst_quad");
        rst            = 1'b0;
        bus.phase_step = 32'h4000_0000;
        bus.bit_in     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick("quad");
            if (m_n >= 19) check("quad_tbl", quad_tbl[(m_n - 19) % 4], 8);
        end

        for (int i = 0; i < 300; i++) begin
            bus.phase_step = $urandom;
            bus.bit_in     = 1'($urandom_range(0, 1));
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
